// File: rtl/div4_vector_seq_pkg.sv
// Shared widths, FSM state type and constants for the word-sliced restoring divider.
package div4_vector_pkg;

   localparam int unsigned W  = 16;
   localparam int unsigned DW = 4 * W;
   localparam int unsigned VW = 2 * W;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   localparam logic [DW-1:0] QuoDivZero = {DW{1'b1}};

endpackage

// File: rtl/div4_vector_seq_if.sv
// Operand/result handshake bundle: master drives operands and out_ready, slave returns results.
interface div4_vector_seq_if #(
   parameter int unsigned W = 16
);

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] y3, y2, y1, y0;
   logic [W-1:0] b1, b0;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] q3, q2, q1, q0;
   logic [W-1:0] r1, r0;
   logic         dz;

   modport master (
      output in_valid, y3, y2, y1, y0, b1, b0, out_ready,
      input  in_ready, out_valid, q3, q2, q1, q0, r1, r0, dz
   );

   modport slave (
      input  in_valid, y3, y2, y1, y0, b1, b0, out_ready,
      output in_ready, out_valid, q3, q2, q1, q0, r1, r0, dz
   );

endinterface

// File: rtl/div4_vector_seq_div_step.sv
// One combinational restoring-division step on the {rem, quo} shift pair.
module div_step
   import div4_vector_pkg::*;
(
   input  logic [VW:0]   rem_i,
   input  logic [DW-1:0] quo_i,
   input  logic [VW-1:0] v_i,
   output logic [VW:0]   rem_o,
   output logic [DW-1:0] quo_o
);

   logic [VW:0] shifted;
   logic        ge;
   logic        unused_rem_msb;

   // rem stays below V, so its MSB is always clear before the shift.
   assign unused_rem_msb = rem_i[VW];
   assign shifted        = {rem_i[VW-1:0], quo_i[DW-1]};
   assign ge             = (shifted >= {1'b0, v_i});

   always_comb begin
      rem_o = shifted;
      quo_o = {quo_i[DW-2:0], 1'b0};
      if (ge) begin
         rem_o = shifted - {1'b0, v_i};
         quo_o = {quo_i[DW-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div4_vector_seq.sv
// Sequential 64/32 unsigned divider with valid/ready on both sides and registered results.
module div4_vector_seq
   import div4_vector_pkg::*;
#(
   parameter int unsigned W     = 16,
   parameter int unsigned STEPS = 1
) (
   input logic              clk,
   input logic              rst_n,
   div4_vector_seq_if.slave bus
);

   localparam int unsigned Iters = DW / STEPS;
   localparam int unsigned CntW  = $clog2(Iters + 1);

   state_e          state_q, state_d;
   logic [VW:0]     rem_q, rem_d;
   logic [DW-1:0]   quo_q, quo_d;
   logic [VW-1:0]   v_q, v_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            dz_q, dz_d;
   logic            valid_q, valid_d;
   logic [DW-1:0]   qres_q, qres_d;
   logic [VW-1:0]   rres_q, rres_d;
   logic            dzo_q, dzo_d;
   logic            div_zero;

   logic [VW:0]     rem_c [STEPS+1];
   logic [DW-1:0]   quo_c [STEPS+1];

   assign rem_c[0] = rem_q;
   assign quo_c[0] = quo_q;

   for (genvar i = 0; i < int'(STEPS); i++) begin : g_step
      div_step u_step (
         .rem_i (rem_c[i]),
         .quo_i (quo_c[i]),
         .v_i   (v_q),
         .rem_o (rem_c[i+1]),
         .quo_o (quo_c[i+1])
      );
   end

   assign div_zero = ({bus.b1, bus.b0} == '0);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      v_d     = v_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      valid_d = valid_q;
      qres_d  = qres_q;
      rres_d  = rres_q;
      dzo_d   = dzo_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               v_d   = {bus.b1, bus.b0};
               quo_d = {bus.y3, bus.y2, bus.y1, bus.y0};
               rem_d = '0;
               dz_d  = div_zero;
               // Divide-by-zero takes a single hold cycle so both paths share the publish stage.
               cnt_d   = div_zero ? CntW'(1) : CntW'(Iters);
               state_d = CALC;
            end
         end
         CALC: begin
            if (!dz_q) begin
               rem_d = rem_c[STEPS];
               quo_d = quo_c[STEPS];
            end
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!valid_q) begin
               valid_d = 1'b1;
               qres_d  = dz_q ? QuoDivZero : quo_q;
               rres_d  = dz_q ? quo_q[VW-1:0] : rem_q[VW-1:0];
               dzo_d   = dz_q;
            end else if (bus.out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         v_q     <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
         valid_q <= 1'b0;
         qres_q  <= '0;
         rres_q  <= '0;
         dzo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         v_q     <= v_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
         valid_q <= valid_d;
         qres_q  <= qres_d;
         rres_q  <= rres_d;
         dzo_q   <= dzo_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = valid_q;
   assign bus.q3        = qres_q[4*W-1:3*W];
   assign bus.q2        = qres_q[3*W-1:2*W];
   assign bus.q1        = qres_q[2*W-1:W];
   assign bus.q0        = qres_q[W-1:0];
   assign bus.r1        = rres_q[2*W-1:W];
   assign bus.r0        = rres_q[W-1:0];
   assign bus.dz        = dzo_q;

endmodule

// File: doc/div4_vector_seq.md
# div4_vector_seq

Sequential unsigned divider that inverts the mul4_vector datapath. It takes a 64-bit dividend as four 16-bit words and a 32-bit divisor as two 16-bit words. It returns a 64-bit quotient and a 32-bit remainder in the same word-sliced format. It serves as the golden inverse check for evolved multiplier individuals and sits behind a valid/ready handshake on both sides.

## Interface
Parameters:
- W, 16, word width; fixed at 16, the only supported value.
- STEPS, 1, restoring-division bits retired per cycle; legal values 1, 2, 4.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand words valid.
- in_ready  out  1  block can accept operands.
- y3, y2, y1, y0  in  W each  dividend words, y3 most significant.
- b1, b0  in  W each  divisor words, b1 most significant.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- q3, q2, q1, q0  out  W each  quotient words, q3 most significant.
- r1, r0  out  W each  remainder words, r1 most significant.
- dz  out  1  divide-by-zero flag for the current result.

## Operation
- States:
  - IDLE: in_ready=1; out_valid=0.
  - CALC: in_ready=0; out_valid=0.
  - DONE: in_ready=0; out_valid=1.
- IDLE: on in_valid, latch D={y3,y2,y1,y0} and V={b1,b0}.
  - V==0: go to DONE and set dz=1.
  - Otherwise: clear the 33-bit partial remainder, load the 64-bit quotient shift register with D, load the step counter with 64/STEPS, and go to CALC.
- CALC, each cycle: apply STEPS restoring steps.
  - Each step shifts {rem, quo} left by 1.
  - If rem ≥ V, subtract V and set quo LSB=1; else set quo LSB=0.
  - Decrement the counter. At count 1, go to DONE.
- DONE: outputs hold stable until out_ready. On out_valid && out_ready, go to IDLE.
- Divide-by-zero result: q = 64'hFFFF_FFFF_FFFF_FFFF; r = D[31:0]; dz=1.
- Otherwise dz=0, q = floor(D/V), r = D mod V, with r < V always.
- Arithmetic is unsigned. The remainder register is 33 bits so the compare never overflows; only its low 32 bits are output.
- in_valid outside IDLE is ignored: no queueing and no overwrite of latched operands.

## Timing
- Reset (async assert, sync release):
  - state=IDLE; in_ready=1; out_valid=0; dz=0.
  - All q and r words are 0; internal registers are 0.
- Reset asserted mid-CALC or in DONE aborts the operation. The result is lost and no out_valid pulse is produced.
- Latency from the accept edge to out_valid high:
  - 64/STEPS + 1 cycles, i.e. 65 for STEPS=1.
  - 2 cycles for divide-by-zero.
- Throughput: one operation per 64/STEPS + 2 cycles minimum. in_ready rises the cycle after the result handshake, so there is no same-cycle accept-after-drain.
- Outputs are registered. There is no combinational path from inputs to outputs except in_ready, which is a decode of state.

## Structure
- Package div4_vector_pkg holds:
  - W and the derived widths DW=4*W and VW=2*W.
  - The state enum {IDLE, CALC, DONE}.
  - The divide-by-zero quotient constant.
- Sub-module div_step (combinational) holds one restoring step: inputs rem, quo, V; outputs next rem and quo.
  - Instantiate it STEPS times in a chain inside a generate loop.
- The top level holds the FSM, counter, operand and result registers, and the handshake.

## Test plan
- Small values: D=100 (y0=16'h0064, others 0), V=7 (b0=16'h0007) -> q0=16'h000E, q3..q1=0, r0=16'h0002, r1=0, dz=0; out_valid exactly 65 cycles after accept (STEPS=1).
- All-ones operands: D=64'hFFFF_FFFF_FFFF_FFFF, V=32'hFFFF_FFFF -> q=64'h0000_0001_0000_0001, r=0.
- Divide by one: D=64'hFFFF_FFFF_FFFF_FFFF, V=1 -> q all ones, r=0, dz=0.
- Divide by zero: D=64'h1234_5678_9ABC_DEF0, V=0 -> q=64'hFFFF_FFFF_FFFF_FFFF, r1=16'h9ABC, r0=16'hDEF0, dz=1; out_valid 2 cycles after accept.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored.
  - Then raise out_ready -> in_ready=1 on the next cycle.
- Reset mid-CALC: drop rst_n at cycle 20 of CALC -> all outputs 0 immediately, in_ready=1 after release, no spurious out_valid; a following 100/7 operation completes correctly.
